bcd_counter_scan: RTL and testbench

//   Parametrised multi-digit BCD up/down counter with a prescaled count tick, synchronous load
//   and a time-multiplexed 7-segment driver. Successor to the fixed-width BCD counter core.

---
 rtl/bcd_counter_scan.sv | 162 ++++++++++++++++
 tb/tb_bcd_counter_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_scan.sv
// rtl/bcd_counter_scan.sv - multi-digit BCD up/down counter with prescaled tick, load and 7-segment scan
// Optional feature macro: BCD_LZB_EN (leading-zero blanking on the scanned display)
module bcd_counter_scan #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  cnt_en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    logic [PW-1:0]         presc_q;
    logic [SW-1:0]         scan_t_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_nxt;
    logic [SW-1:0]         scan_t_nxt;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   step_val;
    logic [4*DIGITS-1:0]   load_clean;
    logic                  wrap;
    logic                  tick;
    logic                  tc_q;
    logic [6:0]            seg_q;
    logic [6:0]            seg_nxt;
    logic [DIGITS-1:0]     sel_q;
    logic [3:0]            cur_digit;

    assign tick = (presc_q == PRE_MAX);

    // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
    always_comb begin : step_calc
        logic       carry;
        logic [3:0] digit;
        step_val = bcd_q;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (digit == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end

    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    always_comb begin
        idx_nxt    = idx_q;
        scan_t_nxt = scan_t_q + SW'(1);
        if (scan_t_q == SCAN_MAX) begin
            scan_t_nxt = '0;
            idx_nxt    = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
    end

    // The display follows the index it will hold after this edge, using the pre-edge count.
    assign cur_digit = bcd_q[{idx_nxt, 2'b00} +: 4];

`ifdef BCD_LZB_EN
    always_comb begin
        seg_nxt = seg_decode(cur_digit);
        for (int i = 1; i < DIGITS; i++) begin
            if ((int'(idx_nxt) == i) && ((bcd_q >> (4*i)) == '0)) begin
                seg_nxt = 7'h00;
            end
        end
    end
`else
    assign seg_nxt = seg_decode(cur_digit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            scan_t_q <= '0;
            idx_q    <= '0;
            bcd_q    <= '0;
            tc_q     <= 1'b0;
            seg_q    <= 7'h3F;
            sel_q    <= DIGITS'(1);
        end else if (ena) begin
            scan_t_q <= scan_t_nxt;
            idx_q    <= idx_nxt;
            sel_q    <= DIGITS'(1) << idx_nxt;
            seg_q    <= seg_nxt;
            if (load) begin
                bcd_q   <= load_clean;
                presc_q <= '0;
                tc_q    <= 1'b0;
            end else begin
                if (cnt_en) begin
                    presc_q <= tick ? '0 : presc_q + PW'(1);
                end
                if (cnt_en && tick) begin
                    bcd_q <= step_val;
                    tc_q  <= wrap;
                end else begin
                    tc_q  <= 1'b0;
                end
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bcd_out = bcd_q;
    assign tc      = tc_q;
    assign seg     = seg_q;
    assign dig_sel = sel_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb/tb_bcd_counter_scan.sv - vector table, directed corners and random model check for bcd_counter_scan
module tb_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        cnt_en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;

    logic [15:0] bcd_out, bcd4;
    logic        tc, tc4;
    logic [6:0]  seg, seg4;
    logic [3:0]  dig_sel, sel4;

    bcd_counter_scan #(.DIGITS(4), .TICK_DIV(1), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cnt_en(cnt_en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .bcd_out(bcd_out), .tc(tc),
        .seg(seg), .dig_sel(dig_sel)
    );

    bcd_counter_scan #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cnt_en(cnt_en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .bcd_out(bcd4), .tc(tc4),
        .seg(seg4), .dig_sel(sel4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ena;
        logic        cnt_en;
        logic        up_dn;
        logic        load;
        logic [15:0] lv;
        logic [15:0] exp_bcd;
        logic        exp_tc;
    } vec_t;

    vec_t vecs[16];

    // Reference model: the count as a plain integer 0..9999 plus an integer scan position.
    int         m_val, m_tc, m_t, m_i;
    logic [6:0] m_seg;
    logic [3:0] m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pw10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pw10(k)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v = 0;
        for (int k = 0; k < 4; k++)
            if (lv[4*k +: 4] <= 4'd9) v = v + int'(lv[4*k +: 4]) * pw10(k);
        return v;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ena = 1'b0; cnt_en = 1'b0; load = 1'b0; up_dn = 1'b1; load_val = '0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_val = 0; m_tc = 0; m_t = 0; m_i = 0; m_seg = 7'h3F; m_sel = 4'b0001;
    endtask

    task automatic model_step();
        int old;
        if (ena) begin
            old = m_val;
            if (load) begin
                m_val = from_load(load_val);
                m_tc  = 0;
            end else if (cnt_en) begin
                if (up_dn) begin
                    m_tc  = (m_val == 9999) ? 1 : 0;
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_tc  = (m_val == 0) ? 1 : 0;
                    m_val = (m_val + 9999) % 10000;
                end
            end else begin
                m_tc = 0;
            end
            if (m_t == 1) begin
                m_t = 0;
                m_i = (m_i + 1) % 4;
            end else begin
                m_t = m_t + 1;
            end
            m_sel = 4'(1 << m_i);
            m_seg = seg_of((old / pw10(m_i)) % 10);
`ifdef BCD_LZB_EN
            if (m_i > 0 && old < pw10(m_i)) m_seg = 7'h00;
`endif
        end else begin
            m_tc = 0;
        end
    endtask

    logic [6:0] scan_seg[8];
    logic [3:0] scan_sel[8];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h9998, 16'h9998, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0F0A, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0500, 16'h0500, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h9A9F, 16'h9090, 1'b0};

`ifdef BCD_LZB_EN
        scan_seg = '{7'h66, 7'h66, 7'h00, 7'h00, 7'h00, 7'h00, 7'h5B, 7'h5B};
`else
        scan_seg = '{7'h66, 7'h66, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h5B, 7'h5B};
`endif
        scan_sel = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

        // Reset values
        do_reset();
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        check("rst_sel", 32'(dig_sel), 32'h1);
        check("rst_seg", 32'(seg), 32'h3F);

        // Vector table
        for (int v = 0; v < 16; v++) begin
            ena = vecs[v].ena; cnt_en = vecs[v].cnt_en; up_dn = vecs[v].up_dn;
            load = vecs[v].load; load_val = vecs[v].lv;
            cyc();
            check($sformatf("vec%0d_bcd", v), 32'(bcd_out), 32'(vecs[v].exp_bcd));
            check($sformatf("vec%0d_tc", v), 32'(tc), 32'(vecs[v].exp_tc));
        end

        // Asynchronous reset in the middle of a count, with no clock edge
        do_reset();
        ena = 1'b1; load = 1'b1; load_val = 16'h0120;
        cyc();
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
        repeat (3) cyc();
        check("mid_pre_bcd", 32'(bcd_out), 32'h0123);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bcd", 32'(bcd_out), 32'h0);
        check("mid_rst_tc", 32'(tc), 32'h0);
        check("mid_rst_sel", 32'(dig_sel), 32'h1);
        check("mid_rst_seg", 32'(seg), 32'h3F);

        // Prescaled counting on the TICK_DIV=4 instance, then freeze with ena=0
        do_reset();
        ena = 1'b1; cnt_en = 1'b1; up_dn = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 3) check("div4_c3", 32'(bcd4), 32'h0);
            if (c == 4) check("div4_c4", 32'(bcd4), 32'h1);
        end
        check("div4_c12", 32'(bcd4), 32'h0003);
        ena = 1'b0;
        repeat (5) cyc();
        check("div4_frozen", 32'(bcd4), 32'h0003);
        check("div4_frozen_tc", 32'(tc4), 32'h0);
        ena = 1'b1;
        cyc();
        check("div4_resume", 32'(bcd4), 32'h0003);

        // Scan of a held 0042
        do_reset();
        ena = 1'b1; load = 1'b1; load_val = 16'h0042;
        cyc();
        load = 1'b0;
        check("scan0_sel", 32'(dig_sel), 32'h1);
        check("scan0_seg", 32'(seg), 32'h3F);
        for (int s = 0; s < 8; s++) begin
            cyc();
            check($sformatf("scan%0d_sel", s + 1), 32'(dig_sel), 32'(scan_sel[s]));
            check($sformatf("scan%0d_seg", s + 1), 32'(seg), 32'(scan_seg[s]));
        end

        // Random stimulus against the integer model
        do_reset();
        for (int r = 0; r < 600; r++) begin
            ena    = ($urandom_range(0, 7) != 0);
            cnt_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            load   = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0: load_val = 16'h9998;
                1: load_val = 16'h0001;
                2: load_val = 16'h0999;
                default: load_val = 16'($urandom);
            endcase
            cyc();
            model_step();
            check("rnd_bcd", 32'(bcd_out), 32'(to_bcd(m_val)));
            check("rnd_tc", 32'(tc), 32'(m_tc));
            check("rnd_sel", 32'(dig_sel), 32'(m_sel));
            check("rnd_seg", 32'(seg), 32'(m_seg));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
